fetch_decode_queue: RTL and testbench

//  Parametrised IF->ID boundary: a DEPTH-entry instruction queue with valid/ready

---
 rtl/fetch_decode_queue_if.sv | 44 ++++
 rtl/fetch_decode_queue.sv | 123 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue_if
//   Handshake bundle for the IF->ID instruction queue. The fetch-side and
//   decode-side valid/ready pairs, the payload, flush and the occupancy
//   count travel together. The two views are:
//     master : the surrounding pipeline or bench. It drives in_valid,
//              in_inst, in_pc_inc, out_ready and flush, and observes the rest.
//     slave  : the queue itself.
//   Signals:
//     in_valid / in_ready      fetch -> queue handshake
//     in_inst / in_pc_inc      fetched instruction and its PC+2
//     out_valid / out_ready    queue -> decode handshake
//     out_inst / out_pc_inc    head instruction and its PC+2
//     flush                    branch taken, discard everything queued
//     count                    occupied entries
// ---------------------------------------------------------------------------
interface fetch_decode_queue_if #(
    parameter int INST_W = 16,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc_inc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc_inc;
    logic              flush;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_inst, in_pc_inc, out_ready, flush,
        input  in_ready, out_valid, out_inst, out_pc_inc, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc_inc, out_ready, flush,
        output in_ready, out_valid, out_inst, out_pc_inc, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// fetch_decode_queue
//   This block sits at the IF->ID boundary. It is a DEPTH-entry instruction
//   queue with valid/ready handshakes on both sides, and it lets fetch run
//   ahead while decode stalls on a hazard. A branch flush squashes every
//   queued entry. When no valid instruction is available, decode sees
//   NOP_INST on out_inst, and out_pc_inc keeps the last value it presented.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous, active-low reset
//     bus    fetch_decode_queue_if.slave. It carries the in/out handshakes,
//            the payload, flush and count.
//
//   Optional feature, selected with the macro FDQ_BYPASS_EN:
//     When the macro is defined and the queue is empty, an incoming
//     instruction is presented at the head in the same cycle. If decode
//     accepts it that cycle, it is never written into storage.
//     When the macro is not defined, every instruction passes through
//     storage and has one cycle of latency.
// ---------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int                INST_W   = 16,
    parameter int                PC_W     = 16,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_decode_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INST_W-1:0] instMem_q [DEPTH];
    logic [PC_W-1:0]   pcMem_q   [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PC_W-1:0]   lastPc_q, lastPc_d;

    logic              isEmpty;
    logic              isFull;
    logic              bypassActive;
    logic              bypassTaken;
    logic              headValid;
    logic [INST_W-1:0] headInst;
    logic [PC_W-1:0]   headPc;
    logic              doPush;
    logic              doPop;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CNT_W'(DEPTH));

`ifdef FDQ_BYPASS_EN
    // An empty queue forwards the fetch payload straight to decode.
    assign bypassActive = isEmpty & bus.in_valid & ~bus.flush;
`else
    assign bypassActive = 1'b0;
`endif
    assign bypassTaken = bypassActive & bus.out_ready;

    assign headValid = ~isEmpty | bypassActive;
    assign headInst  = bypassActive ? bus.in_inst   : instMem_q[rdPtr_q];
    assign headPc    = bypassActive ? bus.in_pc_inc : pcMem_q[rdPtr_q];

    // in_ready depends only on registered occupancy. A full queue refuses
    // input even while decode is popping, so there is no same-cycle
    // pass-through.
    assign bus.in_ready   = ~isFull;
    assign bus.out_valid  = headValid;
    assign bus.out_inst   = headValid ? headInst : NOP_INST;
    assign bus.out_pc_inc = headValid ? headPc : lastPc_q;
    assign bus.count      = count_q;

    // A bypassed instruction that decode consumes at once never touches
    // storage or the count. Flush blocks both push and pop.
    always_comb begin
        doPush = bus.in_valid & ~isFull & ~bus.flush & ~bypassTaken;
        doPop  = headValid & bus.out_ready & ~bus.flush & ~bypassTaken;
    end

    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        lastPc_d = headValid ? headPc : lastPc_q;
        if (bus.flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap for free.
            // The count tells a full queue apart from an empty one.
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            lastPc_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            lastPc_q <= lastPc_d;
        end
    end

    // Storage has no reset. Entries are only read after they are written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            instMem_q[wrPtr_q] <= bus.in_inst;
            pcMem_q[wrPtr_q]   <= bus.in_pc_inc;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_queue
//   Directed bench for fetch_decode_queue with DEPTH=4. It exercises fill
//   and full back-pressure, pointer wrap, flush, decode stall, the
//   empty-queue path (which depends on FDQ_BYPASS_EN) and an asynchronous
//   reset in the middle of traffic. Every expected value is written out by
//   hand.
// ---------------------------------------------------------------------------
module tb_fetch_decode_queue;
    localparam int INST_W = 16;
    localparam int PC_W   = 16;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;

    int assertCount = 0;
    int failCount   = 0;

    fetch_decode_queue_if #(.INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH)) fdqBus ();

    fetch_decode_queue #(
        .INST_W(INST_W), .PC_W(PC_W), .DEPTH(DEPTH), .NOP_INST(16'h0800)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fdqBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something unexpected stalls the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the inputs, then waits 1 time unit so the combinational head can settle.
    task automatic applyStimulus(input logic valid, input logic [15:0] inst,
                                 input logic [15:0] pc, input logic ready,
                                 input logic fl);
        fdqBus.in_valid  = valid;
        fdqBus.in_inst   = inst;
        fdqBus.in_pc_inc = pc;
        fdqBus.out_ready = ready;
        fdqBus.flush     = fl;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] expInst;

        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        $display("[TB] reset state");
        checkOutput("rst_count",    32'(fdqBus.count),      32'd0);
        checkOutput("rst_valid",    32'(fdqBus.out_valid),  32'd0);
        checkOutput("rst_inst",     32'(fdqBus.out_inst),   32'h0800);
        checkOutput("rst_pc",       32'(fdqBus.out_pc_inc), 32'h0);
        checkOutput("rst_in_ready", 32'(fdqBus.in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();

        // Fill the queue, then drain it.
        $display("[TB] fill and drain");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'(32'hA001 + i), 16'(32'h0100 + 2 * i), 1'b0, 1'b0);
            nextCycle();
            checkOutput("fill_count", 32'(fdqBus.count),    32'(i + 1));
            checkOutput("fill_head",  32'(fdqBus.out_inst), 32'hA001);
        end
        checkOutput("full_in_ready", 32'(fdqBus.in_ready),   32'd0);
        checkOutput("full_head_pc",  32'(fdqBus.out_pc_inc), 32'h0100);
        applyStimulus(1'b1, 16'hA005, 16'h0108, 1'b0, 1'b0);
        nextCycle();
        checkOutput("full_ignore_count", 32'(fdqBus.count),    32'd4);
        checkOutput("full_ignore_head",  32'(fdqBus.out_inst), 32'hA001);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_valid", 32'(fdqBus.out_valid), 32'd1);
            checkOutput("drain_inst",  32'(fdqBus.out_inst),  32'(32'hA001 + i));
            nextCycle();
        end
        checkOutput("drained_valid", 32'(fdqBus.out_valid),  32'd0);
        checkOutput("drained_inst",  32'(fdqBus.out_inst),   32'h0800);
        checkOutput("drained_pc",    32'(fdqBus.out_pc_inc), 32'h0106);
        checkOutput("drained_count", 32'(fdqBus.count),      32'd0);

        // Pointer wrap with two entries kept in flight.
        $display("[TB] wrap");
        applyStimulus(1'b1, 16'hC000, 16'h0400, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 16'hC001, 16'h0402, 1'b0, 1'b0);
        nextCycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 16'(32'hC000 + k + 2), 16'(32'h0400 + 2 * (k + 2)), 1'b1, 1'b0);
            checkOutput("wrap_head",  32'(fdqBus.out_inst),   32'(32'hC000 + k));
            checkOutput("wrap_pc",    32'(fdqBus.out_pc_inc), 32'(32'h0400 + 2 * k));
            checkOutput("wrap_count", 32'(fdqBus.count),      32'd2);
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("wrap_tail0", 32'(fdqBus.out_inst), 32'hC00A);
        nextCycle();
        checkOutput("wrap_tail1", 32'(fdqBus.out_inst), 32'hC00B);
        nextCycle();
        checkOutput("wrap_empty", 32'(fdqBus.out_valid), 32'd0);

        // Flush with a same-cycle push.
        $display("[TB] flush");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(32'hD000 + i), 16'(32'h0500 + 2 * i), 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("preflush_count", 32'(fdqBus.count), 32'd3);
        applyStimulus(1'b1, 16'hB0B0, 16'h0600, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checkOutput("flush_count", 32'(fdqBus.count),     32'd0);
        checkOutput("flush_valid", 32'(fdqBus.out_valid), 32'd0);
        checkOutput("flush_inst",  32'(fdqBus.out_inst),  32'h0800);
        applyStimulus(1'b1, 16'h0C0C, 16'h0700, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checkOutput("post_flush_head",  32'(fdqBus.out_inst), 32'h0C0C);
        checkOutput("post_flush_count", 32'(fdqBus.count),    32'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("post_flush_empty", 32'(fdqBus.out_valid), 32'd0);

        // Decode stall holds the head.
        $display("[TB] stall");
        applyStimulus(1'b1, 16'h1234, 16'h0010, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 16'h5678, 16'h0012, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_inst",  32'(fdqBus.out_inst),   32'h1234);
            checkOutput("stall_pc",    32'(fdqBus.out_pc_inc), 32'h0010);
            checkOutput("stall_valid", 32'(fdqBus.out_valid),  32'd1);
            nextCycle();
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checkOutput("stall_next_inst", 32'(fdqBus.out_inst),   32'h5678);
        checkOutput("stall_next_pc",   32'(fdqBus.out_pc_inc), 32'h0012);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("stall_drained", 32'(fdqBus.count), 32'd0);

        // Empty queue with a fetch and an accepting decode.
        $display("[TB] empty-queue path");
        applyStimulus(1'b1, 16'hBEEF, 16'h0200, 1'b1, 1'b0);
`ifdef FDQ_BYPASS_EN
        checkOutput("bypass_inst",  32'(fdqBus.out_inst),   32'hBEEF);
        checkOutput("bypass_valid", 32'(fdqBus.out_valid),  32'd1);
        checkOutput("bypass_pc",    32'(fdqBus.out_pc_inc), 32'h0200);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("bypass_count", 32'(fdqBus.count),     32'd0);
        checkOutput("bypass_after", 32'(fdqBus.out_valid), 32'd0);
`else
        checkOutput("nobypass_inst",  32'(fdqBus.out_inst),  32'h0800);
        checkOutput("nobypass_valid", 32'(fdqBus.out_valid), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        checkOutput("nobypass_next",  32'(fdqBus.out_inst), 32'hBEEF);
        checkOutput("nobypass_count", 32'(fdqBus.count),    32'd1);
        nextCycle();
        checkOutput("nobypass_empty", 32'(fdqBus.out_valid), 32'd0);
`endif

        // Asynchronous reset in the middle of traffic.
        $display("[TB] async reset mid-traffic");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(32'hE000 + i), 16'(32'h0800 + 2 * i), 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("prereset_count", 32'(fdqBus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_count",    32'(fdqBus.count),     32'd0);
        checkOutput("async_rst_valid",    32'(fdqBus.out_valid), 32'd0);
        checkOutput("async_rst_inst",     32'(fdqBus.out_inst),  32'h0800);
        checkOutput("async_rst_in_ready", 32'(fdqBus.in_ready),  32'd1);
        nextCycle();
        checkOutput("held_rst_count", 32'(fdqBus.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h7777, 16'h0900, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        expInst = 16'h7777;
        checkOutput("after_rst_head",  32'(fdqBus.out_inst), 32'(expInst));
        checkOutput("after_rst_count", 32'(fdqBus.count),    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
